i2c_reg_ctrl: RTL

I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

---
 rtl/i2c_reg_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: sequences the bytes of an I2C register write or read through
// a byte-level bit engine (Cmd/Go/Tx_DATA out, Trans_Done/ack_o/Rx_DATA in).
module i2c_reg_ctrl #(
  parameter bit ABORT_ON_NACK = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Wr_req,
  input  logic        Rd_req,
  input  logic [6:0]  Dev_addr,
  input  logic [15:0] Reg_addr,
  input  logic        Addr_mode,
  input  logic [7:0]  Wr_data,
  output logic [7:0]  Rd_data,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [5:0]  Cmd,
  output logic        Go,
  output logic [7:0]  Tx_DATA,
  input  logic [7:0]  Rx_DATA,
  input  logic        Trans_Done,
  input  logic        ack_o
);

  localparam logic [5:0] CMD_WR   = 6'b000001;
  localparam logic [5:0] CMD_STA  = 6'b000010;
  localparam logic [5:0] CMD_RD   = 6'b000100;
  localparam logic [5:0] CMD_STO  = 6'b001000;
  localparam logic [5:0] CMD_NACK = 6'b100000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t      state_reg;
  logic [2:0]  idx_reg;
  logic        is_read_reg;
  logic        mode_reg;
  logic [6:0]  dev_reg;
  logic [15:0] reg_addr_reg;
  logic [7:0]  wdata_reg;
  logic [5:0]  cmd_reg;
  logic [7:0]  tx_reg;
  logic        go_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        err_reg;
  logic [7:0]  rd_data_reg;

  logic [2:0]  last_idx;
  logic [2:0]  idx_next;
  logic        nack_seen;
  logic [13:0] first_byte;
  logic [13:0] next_byte;

  // Returns {cmd, tx} for byte slot idx. In 8-bit address mode the register
  // high byte slot is skipped, so slots after 0 shift up by one to share the
  // same decode as 16-bit mode.
  function automatic logic [13:0] byte_sel(
    input logic        rd,
    input logic        mode,
    input logic [6:0]  dev,
    input logic [15:0] ra,
    input logic [7:0]  wd,
    input logic [2:0]  idx
  );
    logic [2:0] kind;
    kind = mode ? idx : ((idx == 3'd0) ? 3'd0 : idx + 3'd1);
    case (kind)
      3'd0:    byte_sel = {CMD_STA | CMD_WR, dev, 1'b0};
      3'd1:    byte_sel = {CMD_WR, ra[15:8]};
      3'd2:    byte_sel = {CMD_WR, ra[7:0]};
      3'd3:    byte_sel = rd ? {CMD_STA | CMD_WR, dev, 1'b1}
                             : {CMD_WR | CMD_STO, wd};
      default: byte_sel = {CMD_RD | CMD_NACK | CMD_STO, 8'h00};
    endcase
  endfunction

  // Byte-list length and per-byte decode for the latched transaction
  assign last_idx   = is_read_reg ? (mode_reg ? 3'd4 : 3'd3)
                                  : (mode_reg ? 3'd3 : 3'd2);
  assign idx_next   = idx_reg + 3'd1;
  assign nack_seen  = cmd_reg[0] & ack_o;
  assign first_byte = byte_sel(~Wr_req, Addr_mode, Dev_addr, Reg_addr, Wr_data, 3'd0);
  assign next_byte  = byte_sel(is_read_reg, mode_reg, dev_reg, reg_addr_reg,
                               wdata_reg, idx_next);

  // Transaction FSM with registered engine-side and status outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg    <= S_IDLE;
      idx_reg      <= 3'd0;
      is_read_reg  <= 1'b0;
      mode_reg     <= 1'b0;
      dev_reg      <= 7'd0;
      reg_addr_reg <= 16'd0;
      wdata_reg    <= 8'd0;
      cmd_reg      <= 6'd0;
      tx_reg       <= 8'd0;
      go_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      rd_data_reg  <= 8'd0;
    end else begin
      go_reg   <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (Wr_req || Rd_req) begin
            // Write has priority when both requests arrive together
            is_read_reg       <= ~Wr_req;
            mode_reg          <= Addr_mode;
            dev_reg           <= Dev_addr;
            reg_addr_reg      <= Reg_addr;
            wdata_reg         <= Wr_data;
            idx_reg           <= 3'd0;
            {cmd_reg, tx_reg} <= first_byte;
            go_reg            <= 1'b1;
            busy_reg          <= 1'b1;
            err_reg           <= 1'b0;
            state_reg         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (Trans_Done) begin
            if (cmd_reg[2]) begin
              rd_data_reg <= Rx_DATA;
            end
            state_reg <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (nack_seen) begin
            err_reg <= 1'b1;
          end
          // An abort on NACK skips the remaining bytes, including the STOP
          if ((idx_reg == last_idx) || (ABORT_ON_NACK && nack_seen)) begin
            cmd_reg   <= 6'd0;
            tx_reg    <= 8'd0;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_FINISH;
          end else begin
            idx_reg           <= idx_next;
            {cmd_reg, tx_reg} <= next_byte;
            go_reg            <= 1'b1;
            state_reg         <= S_ISSUE;
          end
        end
        S_FINISH: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign Cmd     = cmd_reg;
  assign Tx_DATA = tx_reg;
  assign Go      = go_reg;
  assign Busy    = busy_reg;
  assign Done    = done_reg;
  assign Err     = err_reg;
  assign Rd_data = rd_data_reg;

endmodule
